// File: rtl/mul_cmd_sequencer.sv
// Command front-end for the shift/add multiply-divide unit: accepts a request,
// pulses the unit, waits for fin (or times out) and returns the result.
module mul_cmd_sequencer #(
    parameter int W           = 8,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic [W-1:0] mu_A,
    output logic [W-1:0] mu_B,
    output logic         mu_pdt,
    output logic         mu_div,
    input  logic [W-1:0] mu_Y,
    input  logic         mu_fin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_y,
    output logic         rsp_err,
    output logic         busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_y;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic w_accept;
    logic w_bad_req;

    assign w_accept  = req_valid && (r_state == IDLE);
    // Illegal op codes and divide-by-zero are answered directly, never issued.
    assign w_bad_req = (req_op != OP_MUL && req_op != OP_DIV) ||
                       (req_op == OP_DIV && req_b == '0);

    // NOTE: every register below, datapath included, is cleared by reset so
    // outputs are deterministic right after it; all state uses non-blocking <=.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= 2'b00;
            r_a     <= '0;
            r_b     <= '0;
            r_y     <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a  <= req_a;
                        r_b  <= req_b;
                        r_op <= req_op;
                        if (w_bad_req) begin
                            r_y     <= '0;
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // fin takes priority over a coincident timeout
                    if (mu_fin) begin
                        r_y     <= mu_Y;
                        r_err   <= 1'b0;
                        r_state <= RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_y     <= '1;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign mu_pdt    = (r_state == ISSUE) && (r_op == OP_MUL);
    assign mu_div    = (r_state == ISSUE) && (r_op == OP_DIV);
    assign mu_A      = r_a;
    assign mu_B      = r_b;
    assign rsp_y     = r_y;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_mul_cmd_sequencer.sv
// Directed bench for mul_cmd_sequencer; the arithmetic unit is played by the
// stimulus itself (mu_fin / mu_Y driven at chosen cycles).
module tb_mul_cmd_sequencer;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [W-1:0] mu_A;
    logic [W-1:0] mu_B;
    logic         mu_pdt;
    logic         mu_div;
    logic [W-1:0] mu_Y;
    logic         mu_fin;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_y;
    logic         rsp_err;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    int pdt_cnt = 0;
    int div_cnt = 0;
    int both_cnt = 0;

    mul_cmd_sequencer #(.W(W), .TIMEOUT_CYC(8), .CNT_W(4)) dut (
        .CLK(CLK), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .mu_A(mu_A), .mu_B(mu_B), .mu_pdt(mu_pdt), .mu_div(mu_div),
        .mu_Y(mu_Y), .mu_fin(mu_fin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Start pulses are tallied mid-cycle, away from the active edge.
    always @(negedge CLK) begin
        if (mu_pdt) pdt_cnt++;
        if (mu_div) div_cnt++;
        if (mu_pdt && mu_div) both_cnt++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0;
        mu_Y = '0; mu_fin = 1'b0; rsp_ready = 1'b0;

        // Reset then idle
        step(); step();
        rst = 1'b0;
        step();
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_mu_pdt",    mu_pdt,    0);
        check("rst_mu_div",    mu_div,    0);
        check("rst_busy",      busy,      0);
        check("rst_rsp_y",     rsp_y,     0);
        check("rst_rsp_err",   rsp_err,   0);

        // Multiply 0x0C * 0x05, fin four cycles after the pulse
        req_valid = 1'b1; req_op = 2'b01; req_a = 8'h0C; req_b = 8'h05;
        step();
        req_valid = 1'b0; req_a = 8'hFF; req_b = 8'hFF;
        check("mul_pdt_pulse", mu_pdt,    1);
        check("mul_no_div",    mu_div,    0);
        check("mul_req_ready", req_ready, 0);
        check("mul_A_issue",   mu_A,      8'h0C);
        check("mul_B_issue",   mu_B,      8'h05);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mul_pdt_low",  mu_pdt,    0);
            check("mul_A_wait",   mu_A,      8'h0C);
            check("mul_B_wait",   mu_B,      8'h05);
            check("mul_no_rsp",   rsp_valid, 0);
        end
        mu_fin = 1'b1; mu_Y = 8'h3C;
        step();
        mu_fin = 1'b0; mu_Y = 8'h00;
        check("mul_rsp_valid", rsp_valid, 1);
        check("mul_rsp_y",     rsp_y,     8'h3C);
        check("mul_rsp_err",   rsp_err,   0);
        check("mul_pdt_count", pdt_cnt,   1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("mul_idle_ready", req_ready, 1);
        check("mul_idle_valid", rsp_valid, 0);

        // Divide 0x64 / 0x07 with five cycles of backpressure
        req_valid = 1'b1; req_op = 2'b10; req_a = 8'h64; req_b = 8'h07;
        step();
        req_valid = 1'b0;
        check("div_pulse",   mu_div, 1);
        check("div_no_pdt",  mu_pdt, 0);
        step(); step();
        mu_fin = 1'b1; mu_Y = 8'h0E;
        step();
        mu_fin = 1'b0; mu_Y = 8'h00;
        for (int i = 0; i < 5; i++) begin
            check("div_bp_y",     rsp_y,     8'h0E);
            check("div_bp_ready", req_ready, 0);
            check("div_bp_valid", rsp_valid, 1);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("div_idle_busy",  busy,      0);
        check("div_idle_ready", req_ready, 1);
        check("div_pulse_cnt",  div_cnt,   1);

        // Divide by zero: immediate error, no pulse
        req_valid = 1'b1; req_op = 2'b10; req_a = 8'h55; req_b = 8'h00;
        step();
        req_valid = 1'b0;
        check("dz_rsp_valid", rsp_valid, 1);
        check("dz_rsp_err",   rsp_err,   1);
        check("dz_rsp_y",     rsp_y,     8'h00);
        check("dz_no_div",    mu_div,    0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("dz_div_cnt",   div_cnt,   1);

        // Illegal op 11; request held during the handshake must not be taken
        req_valid = 1'b1; req_op = 2'b11; req_a = 8'h01; req_b = 8'h02;
        step();
        check("op11_rsp_valid", rsp_valid, 1);
        check("op11_rsp_err",   rsp_err,   1);
        check("op11_rsp_y",     rsp_y,     8'h00);
        check("op11_no_pdt",    mu_pdt,    0);
        check("op11_no_div",    mu_div,    0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0; req_valid = 1'b0;
        check("op11_not_reaccepted", busy, 0);
        step();
        check("op11_idle", busy, 0);

        // Timeout with TIMEOUT_CYC = 8, late fin ignored in RESP
        req_valid = 1'b1; req_op = 2'b01; req_a = 8'h02; req_b = 8'h03;
        step();
        req_valid = 1'b0;
        check("to_pdt", mu_pdt, 1);
        step();
        for (int i = 0; i < 7; i++) step();
        check("to_still_wait", rsp_valid, 0);
        step();
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err",   rsp_err,   1);
        check("to_rsp_y",     rsp_y,     8'hFF);
        mu_fin = 1'b1; mu_Y = 8'hAA;
        step();
        mu_fin = 1'b0; mu_Y = 8'h00;
        check("to_late_y",     rsp_y,     8'hFF);
        check("to_late_err",   rsp_err,   1);
        check("to_late_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset two cycles after the pulse, then a stray fin
        req_valid = 1'b1; req_op = 2'b01; req_a = 8'h04; req_b = 8'h04;
        step();
        req_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_busy",  busy,      0);
        check("mr_valid", rsp_valid, 0);
        check("mr_mu_A",  mu_A,      8'h00);
        mu_fin = 1'b1; mu_Y = 8'h77;
        step();
        mu_fin = 1'b0; mu_Y = 8'h00;
        check("mr_fin_busy",  busy,      0);
        check("mr_fin_valid", rsp_valid, 0);

        // Normal multiply 3 * 3 after the mid-operation reset
        req_valid = 1'b1; req_op = 2'b01; req_a = 8'h03; req_b = 8'h03;
        step();
        req_valid = 1'b0;
        check("m33_pdt", mu_pdt, 1);
        step();
        mu_fin = 1'b1; mu_Y = 8'h09;
        step();
        mu_fin = 1'b0; mu_Y = 8'h00;
        check("m33_valid", rsp_valid, 1);
        check("m33_y",     rsp_y,     8'h09);
        check("m33_err",   rsp_err,   0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("m33_idle",  busy, 0);

        check("total_pdt_pulses", pdt_cnt,  4);
        check("total_div_pulses", div_cnt,  1);
        check("never_both",       both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
